// File: rtl/fetch_queue.sv
// fetch_queue: DEPTH-entry {instr, pc, pc+4} buffer between fetch and decode with valid/ready on both sides.
// Define FETCH_QUEUE_BYPASS_EN to let an entry pass straight to decode when the queue is empty.
module fetch_queue #(
   parameter int DEPTH  = 4,
   parameter int DATA_W = 32
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [DATA_W-1:0]         in_instr,
   input  logic [DATA_W-1:0]         in_pc,
   input  logic [DATA_W-1:0]         in_pc_add4,
   input  logic                      flush,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [DATA_W-1:0]         out_instr,
   output logic [DATA_W-1:0]         out_pc,
   output logic [DATA_W-1:0]         out_pc_add4,
   output logic [$clog2(DEPTH):0]    count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   typedef struct packed {
      logic [DATA_W-1:0] instr;
      logic [DATA_W-1:0] pc;
      logic [DATA_W-1:0] pc_add4;
   } entry_t;

   entry_t          mem [DEPTH];
   entry_t          in_entry;
   entry_t          head;
   logic [AW-1:0]   wr_ptr;
   logic [AW-1:0]   rd_ptr;
   logic            bypass;
   logic            push;
   logic            pop_mem;

   // NOTE: every signal written here gets a value before any condition, so no latch is inferred.
   always_comb begin
      bypass   = 1'b0;
`ifdef FETCH_QUEUE_BYPASS_EN
      bypass   = (count == '0) && !flush && !reset;
`endif
      in_entry = '{instr: in_instr, pc: in_pc, pc_add4: in_pc_add4};
      in_ready = (count < CW'(DEPTH)) && !flush && !reset;
      out_valid = ((count != '0) && !flush) || (bypass && in_valid);
      head     = bypass ? in_entry : mem[rd_ptr];
      // A bypassed entry taken by decode in the same cycle never touches storage.
      push     = in_valid && in_ready && !(bypass && out_ready);
      pop_mem  = (count != '0) && !flush && out_ready;
   end

   assign out_instr   = head.instr;
   assign out_pc      = head.pc;
   assign out_pc_add4 = head.pc_add4;

   // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         // NOTE: storage is cleared on reset so decode sees a NOP head; flush deliberately leaves it alone.
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= in_entry;
            wr_ptr      <= wr_ptr + AW'(1);
         end
         if (pop_mem) rd_ptr <= rd_ptr + AW'(1);
         count <= count + CW'(push) - CW'(pop_mem);
      end
   end

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: scenario tasks plus a scoreboard monitor that checks every pop in order.
module tb_fetch_queue;

   localparam int DEPTH  = 4;
   localparam int DATA_W = 32;
`ifdef FETCH_QUEUE_BYPASS_EN
   localparam int STREAM_CNT = 0;
`else
   localparam int STREAM_CNT = 1;
`endif

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic              in_valid = 1'b0;
   logic              in_ready;
   logic [DATA_W-1:0] in_instr = '0;
   logic [DATA_W-1:0] in_pc = '0;
   logic [DATA_W-1:0] in_pc_add4 = '0;
   logic              flush = 1'b0;
   logic              out_valid;
   logic              out_ready = 1'b0;
   logic [DATA_W-1:0] out_instr;
   logic [DATA_W-1:0] out_pc;
   logic [DATA_W-1:0] out_pc_add4;
   logic [$clog2(DEPTH):0] count;

   typedef struct {
      logic [DATA_W-1:0] instr;
      logic [DATA_W-1:0] pc;
      logic [DATA_W-1:0] pc_add4;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   fetch_queue #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_instr(in_instr), .in_pc(in_pc), .in_pc_add4(in_pc_add4),
      .flush(flush),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_instr(out_instr), .out_pc(out_pc), .out_pc_add4(out_pc_add4),
      .count(count)
   );

   always #5 clk = ~clk;

   // Scoreboard: pops are compared first, then the accepted entry is queued; flush/reset empty it.
   always @(negedge clk) begin
      exp_t e;
      logic bypassed;
      bypassed = 1'b0;
      if (out_valid && out_ready) begin
         if (sb.size() > 0) begin
            e = sb.pop_front();
            n_checks++;
            if ({out_instr, out_pc, out_pc_add4} !== {e.instr, e.pc, e.pc_add4}) begin
               n_fail++;
               $display("FAIL pop_order: got instr=%h pc=%h pc4=%h expected instr=%h pc=%h pc4=%h",
                        out_instr, out_pc, out_pc_add4, e.instr, e.pc, e.pc_add4);
            end
         end else begin
`ifdef FETCH_QUEUE_BYPASS_EN
            bypassed = 1'b1;
            n_checks++;
            if ({out_instr, out_pc, out_pc_add4} !== {in_instr, in_pc, in_pc_add4}) begin
               n_fail++;
               $display("FAIL bypass_data: got pc=%h expected pc=%h", out_pc, in_pc);
            end
`else
            n_checks++;
            n_fail++;
            $display("FAIL pop_empty: got out_valid=1 pc=%h expected no entry", out_pc);
`endif
         end
      end
      if (in_valid && in_ready && !bypassed)
         sb.push_back('{instr: in_instr, pc: in_pc, pc_add4: in_pc_add4});
      if (reset || flush) sb.delete();
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [DATA_W-1:0] pc, input logic [DATA_W-1:0] instr);
      in_pc      = pc;
      in_pc_add4 = pc + 32'd4;
      in_instr   = instr;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      tick();
      tick();
      @(negedge clk);
      n_checks++;
      if ({in_ready, out_valid, count, out_instr} !== {1'b0, 1'b0, 3'd0, 32'd0}) begin
         n_fail++;
         $display("FAIL reset_hold: got in_ready=%b out_valid=%b count=%0d instr=%h expected 0 0 0 0",
                  in_ready, out_valid, count, out_instr);
      end
      reset = 1'b0;
      tick();
      @(negedge clk);
      n_checks++;
      if ({in_ready, out_valid, count, out_instr, out_pc} !== {1'b1, 1'b0, 3'd0, 32'd0, 32'd0}) begin
         n_fail++;
         $display("FAIL reset_release: got in_ready=%b out_valid=%b count=%0d instr=%h pc=%h expected 1 0 0 0 0",
                  in_ready, out_valid, count, out_instr, out_pc);
      end
      tick();
   endtask

   task automatic test_fill_drain();
      out_ready = 1'b0;
      in_valid  = 1'b1;
      for (int i = 0; i < 4; i++) begin
         drive(32'(4 * i), 32'h2008_0001 + 32'(i));
         @(negedge clk);
         n_checks++;
         if (in_ready !== 1'b1 || count !== 3'(i)) begin
            n_fail++;
            $display("FAIL fill_step%0d: got in_ready=%b count=%0d expected 1 %0d", i, in_ready, count, i);
         end
         tick();
      end
      drive(32'h10, 32'h2008_0005);
      @(negedge clk);
      n_checks++;
      if ({count, in_ready, out_valid, out_pc} !== {3'd4, 1'b0, 1'b1, 32'h0}) begin
         n_fail++;
         $display("FAIL full: got count=%0d in_ready=%b out_valid=%b pc=%h expected 4 0 1 0",
                  count, in_ready, out_valid, out_pc);
      end
      tick();
      @(negedge clk);
      n_checks++;
      if (count !== 3'd4) begin
         n_fail++;
         $display("FAIL fifth_held: got count=%0d expected 4", count);
      end
      tick();
      in_valid  = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         n_checks++;
         if (out_pc !== 32'(4 * i)) begin
            n_fail++;
            $display("FAIL drain_pc%0d: got %h expected %h", i, out_pc, 32'(4 * i));
         end
         tick();
      end
      @(negedge clk);
      n_checks++;
      if (out_valid !== 1'b0 || count !== 3'd0) begin
         n_fail++;
         $display("FAIL drained: got out_valid=%b count=%0d expected 0 0", out_valid, count);
      end
      out_ready = 1'b0;
      tick();
   endtask

   task automatic test_streaming();
      in_valid  = 1'b1;
      out_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         drive(32'(4 * i), 32'h1000_0000 + 32'(i));
         @(negedge clk);
         n_checks++;
         if (count !== ((i == 0) ? 3'd0 : 3'(STREAM_CNT))) begin
            n_fail++;
            $display("FAIL stream_count%0d: got %0d expected %0d", i, count, (i == 0) ? 0 : STREAM_CNT);
         end
         tick();
      end
      in_valid = 1'b0;
      tick();
      @(negedge clk);
      n_checks++;
      if (count !== 3'd0 || out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL stream_end: got count=%0d out_valid=%b expected 0 0", count, out_valid);
      end
      out_ready = 1'b0;
      tick();
   endtask

   task automatic test_wrap();
      for (int i = 0; i < 6; i++) begin
         in_valid  = 1'b1;
         out_ready = 1'b0;
         drive(32'h80 + 32'(4 * i), 32'h3000_0000 + 32'(i));
         tick();
         in_valid  = 1'b0;
         out_ready = 1'b1;
         @(negedge clk);
         n_checks++;
         if ({count, out_valid, out_pc} !== {3'd1, 1'b1, 32'h80 + 32'(4 * i)}) begin
            n_fail++;
            $display("FAIL wrap%0d: got count=%0d out_valid=%b pc=%h expected 1 1 %h",
                     i, count, out_valid, out_pc, 32'h80 + 32'(4 * i));
         end
         tick();
      end
      out_ready = 1'b0;
   endtask

   task automatic test_flush();
      out_ready = 1'b0;
      in_valid  = 1'b1;
      for (int i = 0; i < 3; i++) begin
         drive(32'h100 + 32'(4 * i), 32'h4000_0000 + 32'(i));
         tick();
      end
      flush     = 1'b1;
      out_ready = 1'b1;
      drive(32'h200, 32'h4000_00ff);
      @(negedge clk);
      n_checks++;
      if ({out_valid, in_ready, count} !== {1'b0, 1'b0, 3'd3}) begin
         n_fail++;
         $display("FAIL flush_cycle: got out_valid=%b in_ready=%b count=%0d expected 0 0 3",
                  out_valid, in_ready, count);
      end
      tick();
      flush     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      @(negedge clk);
      n_checks++;
      if (count !== 3'd0 || out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL flush_after: got count=%0d out_valid=%b expected 0 0", count, out_valid);
      end
      tick();
      in_valid = 1'b1;
      drive(32'h40, 32'h4000_0040);
      tick();
      in_valid = 1'b0;
      @(negedge clk);
      n_checks++;
      if ({count, out_valid, out_pc} !== {3'd1, 1'b1, 32'h40}) begin
         n_fail++;
         $display("FAIL flush_refill: got count=%0d out_valid=%b pc=%h expected 1 1 00000040",
                  count, out_valid, out_pc);
      end
      tick();
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
   endtask

   task automatic test_full_pop();
      out_ready = 1'b0;
      in_valid  = 1'b1;
      for (int i = 0; i < 4; i++) begin
         drive(32'h300 + 32'(4 * i), 32'h5000_0000 + 32'(i));
         tick();
      end
      drive(32'h310, 32'h5000_0004);
      out_ready = 1'b1;
      @(negedge clk);
      n_checks++;
      if ({in_ready, out_valid, count, out_pc} !== {1'b0, 1'b1, 3'd4, 32'h300}) begin
         n_fail++;
         $display("FAIL full_pop_cycle: got in_ready=%b out_valid=%b count=%0d pc=%h expected 0 1 4 00000300",
                  in_ready, out_valid, count, out_pc);
      end
      tick();
      in_valid  = 1'b0;
      out_ready = 1'b0;
      @(negedge clk);
      n_checks++;
      if (count !== 3'd3) begin
         n_fail++;
         $display("FAIL full_pop_count: got %0d expected 3", count);
      end
      tick();
      out_ready = 1'b1;
      repeat (3) tick();
      out_ready = 1'b0;
      @(negedge clk);
      n_checks++;
      if (count !== 3'd0) begin
         n_fail++;
         $display("FAIL full_pop_drain: got %0d expected 0", count);
      end
      tick();
   endtask

   task automatic test_mid_reset();
      out_ready = 1'b0;
      in_valid  = 1'b1;
      for (int i = 0; i < 2; i++) begin
         drive(32'h500 + 32'(4 * i), 32'h6000_0000 + 32'(i));
         tick();
      end
      in_valid = 1'b0;
      reset    = 1'b1;
      @(negedge clk);
      n_checks++;
      if (in_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL mid_reset_ready: got %b expected 0", in_ready);
      end
      tick();
      @(negedge clk);
      n_checks++;
      if ({count, out_valid, out_instr, out_pc_add4} !== {3'd0, 1'b0, 32'd0, 32'd0}) begin
         n_fail++;
         $display("FAIL mid_reset_state: got count=%0d out_valid=%b instr=%h pc4=%h expected 0 0 0 0",
                  count, out_valid, out_instr, out_pc_add4);
      end
      reset = 1'b0;
      tick();
      @(negedge clk);
      n_checks++;
      if (in_ready !== 1'b1 || count !== 3'd0) begin
         n_fail++;
         $display("FAIL mid_reset_release: got in_ready=%b count=%0d expected 1 0", in_ready, count);
      end
      tick();
   endtask

   initial begin
      test_reset();
      test_fill_drain();
      test_streaming();
      test_wrap();
      test_flush();
      test_full_pop();
      test_mid_reset();
      n_checks++;
      if (sb.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_leftover: got %0d entries expected 0", sb.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
